// File: rtl/fir_seq_ctrl_if.sv
// Sample-in / filter-pass-out bundle between a stereo sample source and the FIR sequencer.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; vld is a strobe, and the sequencer flags an overrun instead of stalling.
// Ports: vld, lft_smpl, rght_smpl, clr_ovr run from source to sequencer.
//        sequencing, lft_out, rght_out, smpl_rdy, ovr run from sequencer to source/FIR.
interface fir_seq_ctrl_if;
  logic        vld;
  logic [15:0] lft_smpl;
  logic [15:0] rght_smpl;
  logic        clr_ovr;
  logic        sequencing;
  logic [15:0] lft_out;
  logic [15:0] rght_out;
  logic        smpl_rdy;
  logic        ovr;

  // Sample source side: drives samples, observes passes.
  modport master (
    output vld, lft_smpl, rght_smpl, clr_ovr,
    input  sequencing, lft_out, rght_out, smpl_rdy, ovr
  );

  // Sequencer side.
  modport slave (
    input  vld, lft_smpl, rght_smpl, clr_ovr,
    output sequencing, lft_out, rght_out, smpl_rdy, ovr
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Stores stereo samples in a circular buffer and replays the newest TAPS of them, oldest first, to a FIR.
// Latency: for a vld in cycle 0, sequencing is high in cycles 1..TAPS and smpl_rdy pulses in cycle TAPS+1.
// Backpressure: none; samples are never dropped, one extra pass can be queued, and further ones set ovr.
// Ports: clk, rst_n (async, active low); bus (slave modport of fir_seq_ctrl_if) carries the sample
//        strobe and data in, plus the pass strobe/data, done pulse and sticky overrun flag out.
// TAPS must not exceed 2**AW - 2. That slack lets writes during a pass land only on slots
// already replayed.
module fir_seq_ctrl #(
  parameter int TAPS = 1021,
  parameter int AW   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  fir_seq_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(TAPS + 1);

  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW-1:0] TAPS_A  = AW'(TAPS);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TAPS_C  = CW'(TAPS);
  localparam logic [CW-1:0] TAPS_M1 = CW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, WARM, SEQ, DONE} state_t;

  // Buffer entries are {left, right}. Contents are not reset: the warm-up refill overwrites
  // every slot a pass could read before the first pass after reset.
  logic [31:0] mem [DEPTH];

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] idx;        // number of window entries already presented
  logic          pending;

  logic [31:0]   wr_dat;
  logic          start;
  logic          ovr_set;
  logic [AW-1:0] newest;     // slot holding the last sample of the window being started
  logic [AW-1:0] first_addr;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_dat;

  assign wr_dat = {bus.lft_smpl, bus.rght_smpl};

  always_comb begin
    start   = 1'b0;
    ovr_set = 1'b0;
    newest  = wr_ptr;
    case (state)
      WARM: start = bus.vld && (count == TAPS_M1);
      IDLE: start = bus.vld;
      SEQ:  ovr_set = bus.vld && pending;
      DONE: begin
        // A vld here is itself the queued pass, and its sample ends the window.
        start   = bus.vld || pending;
        ovr_set = bus.vld && pending;
        newest  = bus.vld ? wr_ptr : wr_ptr - ONE_A;
      end
      default: ;
    endcase
    first_addr = newest + ONE_A - TAPS_A;
    rd_addr    = start ? first_addr : rd_ptr;
    // Forward a same-cycle write so a window may end on the sample arriving this cycle.
    rd_dat     = (bus.vld && (rd_addr == wr_ptr)) ? wr_dat : mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (bus.vld) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WARM;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      idx            <= '0;
      pending        <= 1'b0;
      bus.sequencing <= 1'b0;
      bus.lft_out    <= '0;
      bus.rght_out   <= '0;
      bus.smpl_rdy   <= 1'b0;
      bus.ovr        <= 1'b0;
    end else begin
      if (bus.vld) begin
        wr_ptr <= wr_ptr + ONE_A;
        if (count != TAPS_C) count <= count + ONE_C;
      end

      // A set event in the same cycle as clr_ovr wins.
      bus.ovr      <= ovr_set | (bus.ovr & ~bus.clr_ovr);
      bus.smpl_rdy <= 1'b0;

      if (start) begin
        state                       <= SEQ;
        bus.sequencing              <= 1'b1;
        {bus.lft_out, bus.rght_out} <= rd_dat;
        rd_ptr                      <= first_addr + ONE_A;
        idx                         <= ONE_C;
        pending                     <= 1'b0;
      end else begin
        case (state)
          SEQ: begin
            if (bus.vld) pending <= 1'b1;
            if (idx == TAPS_C) begin
              state          <= DONE;
              bus.sequencing <= 1'b0;
              bus.lft_out    <= '0;
              bus.rght_out   <= '0;
              bus.smpl_rdy   <= 1'b1;
            end else begin
              {bus.lft_out, bus.rght_out} <= rd_dat;
              rd_ptr                      <= rd_ptr + ONE_A;
              idx                         <= idx + ONE_C;
            end
          end
          // Every way out of DONE into a new pass is covered by start.
          DONE:    state <= IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: a history-based model compared every cycle, plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_fir_seq_ctrl;
  localparam int TAPS = 1021;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_seq_ctrl_if bus();

  fir_seq_ctrl #(.TAPS(TAPS), .AW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n      = 1;      // global sample number; L = n, R = n ^ 16'h5a5a

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cyc=%0d %s: got %0h, want %0h", cyc, nm, act, exp);
    end
  endtask

  // ---------------- model: history of samples since reset, pass position, queued flag
  logic [31:0] hist[$];
  int          m_pos = 0;    // 0 = no pass, 1..TAPS = presenting entry, TAPS+1 = done cycle
  int          m_end = 0;    // history index of the newest sample of the window
  bit          m_pend = 0;
  bit          m_ovr = 0;
  bit          started = 0;

  task automatic model_clear();
    hist.delete();
    m_pos = 0; m_end = 0; m_pend = 0; m_ovr = 0;
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    bit ovr_set;
    bit v;
    started = 1;
    cyc++;
    ovr_set = 0;
    v = bus.vld;
    if (!rst_n) model_clear();
    else begin
      if (v) hist.push_back({bus.lft_smpl, bus.rght_smpl});
      if (m_pos >= 1 && m_pos <= TAPS) begin
        if (v) begin
          if (m_pend) ovr_set = 1;
          m_pend = 1;
        end
        m_pos++;
      end else if (m_pos == TAPS + 1) begin
        if (v && m_pend) ovr_set = 1;
        if (v || m_pend) begin
          m_pos = 1; m_end = hist.size() - 1; m_pend = 0;
        end else m_pos = 0;
      end else if (v && hist.size() >= TAPS) begin
        m_pos = 1; m_end = hist.size() - 1;
      end
      m_ovr = ovr_set | (m_ovr & !bus.clr_ovr);
    end
  end

  function automatic logic [31:0] m_dat();
    if (m_pos >= 1 && m_pos <= TAPS) return hist[m_end - TAPS + m_pos];
    return 32'h0;
  endfunction

  // ---------------- compare + pass monitor (negedge, away from the active edge)
  bit          prev_seq = 0;
  logic [15:0] prev_lft = '0;
  int          run_len = 0;
  int          run_first = 0;
  int          run_last = 0;
  bit          seq_seen = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (started) begin
      e = m_dat();
      chk("sequencing", 32'(bus.sequencing), 32'(m_pos >= 1 && m_pos <= TAPS));
      chk("lft_out",    32'(bus.lft_out),  32'(e[31:16]));
      chk("rght_out",   32'(bus.rght_out), 32'(e[15:0]));
      chk("smpl_rdy",   32'(bus.smpl_rdy), 32'(m_pos == TAPS + 1));
      chk("ovr",        32'(bus.ovr),      32'(m_ovr));
      if (bus.sequencing) begin
        seq_seen = 1;
        chk("lane_pair", 32'(bus.rght_out), 32'(bus.lft_out ^ 16'h5a5a));
        if (prev_seq) begin
          chk("contiguous", 32'(bus.lft_out), 32'(prev_lft + 16'd1));
          run_len++;
        end else begin
          run_len = 1;
          run_first = int'(bus.lft_out);
        end
        run_last = int'(bus.lft_out);
        prev_lft = bus.lft_out;
      end
      prev_seq = bus.sequencing;
    end
  end

  // ---------------- stimulus helpers; the main thread lives at posedge+1
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit clr = 0);
    bus.vld       = 1'b1;
    bus.clr_ovr   = clr;
    bus.lft_smpl  = n[15:0];
    bus.rght_smpl = n[15:0] ^ 16'h5a5a;
    n++;
    tick();
    bus.vld     = 1'b0;
    bus.clr_ovr = 1'b0;
  endtask

  // Ends in the smpl_rdy cycle; an expired bound counts as a failure.
  task automatic wait_rdy(input string nm);
    int k;
    k = 0;
    while (!bus.smpl_rdy && k < 2 * TAPS + 10) begin
      tick();
      k++;
    end
    checks++;
    if (!bus.smpl_rdy) begin
      errors++;
      $display("FAIL cyc=%0d %s: smpl_rdy not seen within %0d cycles", cyc, nm, k);
    end
  endtask

  initial begin
    int first_after_rst;
    bus.vld = 0; bus.clr_ovr = 0; bus.lft_smpl = '0; bus.rght_smpl = '0;
    repeat (3) tick();
    chk("rst_sequencing", 32'(bus.sequencing), 32'd0);
    chk("rst_lft",        32'(bus.lft_out),  32'd0);
    chk("rst_rght",       32'(bus.rght_out), 32'd0);
    chk("rst_smpl_rdy",   32'(bus.smpl_rdy), 32'd0);
    chk("rst_ovr",        32'(bus.ovr),      32'd0);
    rst_n = 1'b1;
    tick();

    // Warm-up and ordering: samples 1..1021.
    repeat (TAPS - 1) send();
    chk("warm_no_seq", 32'(seq_seen | bus.sequencing), 32'd0);
    send();
    chk("warm_seq_rise", 32'(bus.sequencing), 32'd1);
    wait_rdy("warm_pass");
    chk("warm_len",   32'(run_len),   32'd1021);
    chk("warm_first", 32'(run_first), 32'd1);
    chk("warm_last",  32'(run_last),  32'd1021);
    tick();
    chk("rdy_one_cycle", 32'(bus.smpl_rdy), 32'd0);

    send();                                  // sample 1022
    wait_rdy("order2");
    chk("order2_first", 32'(run_first), 32'd2);
    chk("order2_last",  32'(run_last),  32'd1022);
    tick();

    // Single pending vld: back-to-back passes, no overrun.
    send();                                  // 1023, window 3..1023
    repeat (500) tick();
    send();                                  // 1024, queued
    wait_rdy("pend_a");
    chk("pend_ovr0", 32'(bus.ovr), 32'd0);
    tick();
    chk("pend_no_idle", 32'(bus.sequencing), 32'd1);
    wait_rdy("pend_b");
    chk("pend_first", 32'(run_first), 32'd4);
    chk("pend_last",  32'(run_last),  32'd1024);
    tick();

    // Two vlds mid-pass: overrun, only one queued pass.
    send();                                  // 1025
    repeat (300) tick();
    send();                                  // 1026
    repeat (100) tick();
    send();                                  // 1027
    chk("ovr_set", 32'(bus.ovr), 32'd1);
    wait_rdy("ovr_a");
    tick();
    chk("ovr_queued", 32'(bus.sequencing), 32'd1);
    wait_rdy("ovr_b");
    chk("ovr_first", 32'(run_first), 32'd7);
    chk("ovr_last",  32'(run_last),  32'd1027);
    tick(); tick();
    chk("ovr_one_pass", 32'(bus.sequencing), 32'd0);

    // clr_ovr: coincident set wins, lone clear takes effect next cycle.
    send();                                  // 1028
    repeat (100) tick();
    send();                                  // 1029 queued
    repeat (100) tick();
    send(1'b1);                              // 1030 overrun with clr_ovr
    chk("clr_set_wins", 32'(bus.ovr), 32'd1);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    chk("clr_alone", 32'(bus.ovr), 32'd0);
    wait_rdy("clr_a");
    tick();
    wait_rdy("clr_b");
    tick();

    // Wrap: 3000 samples, windows cross the pointer wrap many times.
    for (int i = 0; i < 3000; i++) begin
      send();
      repeat (15) tick();
    end
    repeat (2 * TAPS + 10) tick();

    // Reset mid-pass.
    send();
    repeat (499) tick();
    chk("pre_rst_seq", 32'(bus.sequencing), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seq",  32'(bus.sequencing), 32'd0);
    chk("midrst_lft",  32'(bus.lft_out),  32'd0);
    chk("midrst_rght", 32'(bus.rght_out), 32'd0);
    chk("midrst_ovr",  32'(bus.ovr),      32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    seq_seen = 0;
    first_after_rst = n;
    repeat (TAPS - 1) send();
    chk("rewarm_no_seq", 32'(seq_seen | bus.sequencing), 32'd0);
    send();
    chk("rewarm_rise", 32'(bus.sequencing), 32'd1);
    wait_rdy("rewarm_pass");
    chk("rewarm_first", 32'(run_first), 32'(first_after_rst & 16'hffff));
    chk("rewarm_len",   32'(run_len),   32'd1021);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
